// File: rtl/cpu_pkg.sv
// Shared CPU types for the fetch/decode boundary: instruction/PC widths,
// the NOP encoding and the queued {instr, pc} entry.
package cpu_pkg;
  localparam int INSTR_W = 9;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP = 9'h000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } if_entry_t;
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for if_id_queue. The master is the fetch/decode
// pair driving the queue; the slave is the queue itself.
interface if_id_queue_if #(parameter int DEPTH = 4);
  import cpu_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CW-1:0]      count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/if_id_queue_mem.sv
// DEPTH-entry {instr, pc} register array: one synchronous write port and
// one asynchronous read port.
module if_id_queue_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  if_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output if_entry_t     rdata
);
  // Contents need no reset: the read port is only observed when count != 0.
  if_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with flush on taken branch/jump.
// Optional zero-latency bypass when empty: define IF_ID_FALL_THROUGH_EN.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  if_id_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, bypass, push, pop, thru, do_push, do_pop;
  if_entry_t     wdata, rdata, out_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    bypass = 1'b0;
`ifdef IF_ID_FALL_THROUGH_EN
    bypass = empty && q.in_valid && !q.flush;
`endif
  end

  assign q.in_ready  = !full;
  assign q.out_valid = !empty || bypass;
  assign q.count     = count_q;

  always_comb begin
    out_entry = '{instr: NOP, pc: '0};
    if (!empty)      out_entry = rdata;
    else if (bypass) out_entry = '{instr: q.in_instr, pc: q.in_pc};
  end

  assign q.out_instr = out_entry.instr;
  assign q.out_pc    = out_entry.pc;

  assign push = q.in_valid && q.in_ready && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;
  // A bypassed word taken in the same cycle never touches storage.
  assign thru    = bypass && q.out_ready;
  assign do_push = push && !thru;
  assign do_pop  = pop && !thru;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wdata = '{instr: q.in_instr, pc: q.in_pc};

  if_id_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
endmodule
